// File: rtl/control_pkg.sv
// Shared types and decode helpers for the accumulator-machine sequencer.
package control_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] SEL_A_ALU = 2'b10;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

  // Non-branch opcodes return 0; callers only consult this for branch opcodes.
  function automatic logic branch_taken(input opcode_t op, input logic z, input logic n);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BGT:  taken = !z && !n;
      OP_BGE:  taken = !n;
      OP_BLT:  taken = n;
      OP_BLE:  taken = n || z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: load has priority over increment, otherwise hold; wraps modulo 2^WIDTH.
// Latency: new value visible the cycle after load/inc; no backpressure.
module program_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer: FETCH/DECODE/EXEC(/MEM), 3 cycles per instruction, 4 for memory operands.
// Backpressure: none; instruction and data memories are fixed-latency synchronous.
module control_unit
  import control_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [DATA_WIDTH-1:0]    instr_data_in,
  input  logic                     flag_Z_in,
  input  logic                     flag_N_in,
  output logic [OPERAND_WIDTH-1:0] instr_addr_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     status_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_reset_out,
  output logic                     data_mem_rd_out,
  output logic                     data_mem_wr_out,
  output logic                     halted_out
);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_WIDTH-1:0]  ir;
  opcode_t                op;
  logic                   pc_load;
  logic                   pc_inc;

  assign op          = opcode_t'(ir[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign operand_out = ir[OPERAND_WIDTH-1:0];

  program_counter #(
    .WIDTH(OPERAND_WIDTH)
  ) u_pc (
    .clk      (clock_in),
    .rst_n    (reset_n_in),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (ir[OPERAND_WIDTH-1:0]),
    .pc       (instr_addr_out)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        ir <= instr_data_in;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_load          = 1'b0;
    pc_inc           = 1'b0;
    alu_op_out       = ALU_ADD;
    sel_A_out        = SEL_A_MEM;
    sel_B_out        = 1'b0;
    acc_wr_out       = 1'b0;
    status_wr_out    = 1'b0;
    acc_reset_out    = 1'b0;
    status_reset_out = 1'b0;
    data_mem_rd_out  = 1'b0;
    data_mem_wr_out  = 1'b0;
    halted_out       = 1'b0;

    case (state)
      INIT: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        state_nxt        = FETCH;
      end
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        case (op)
          OP_HLT: state_nxt = HALT;
          OP_STO: begin
            data_mem_wr_out = 1'b1;
            pc_inc          = 1'b1;
          end
          OP_LD, OP_ADD, OP_SUB: begin
            data_mem_rd_out = 1'b1;
            state_nxt       = MEM;
          end
          OP_LDI: begin
            sel_A_out  = SEL_A_EXT;
            acc_wr_out = 1'b1;
            pc_inc     = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            sel_A_out     = SEL_A_ALU;
            sel_B_out     = 1'b1;
            alu_op_out    = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
            pc_inc        = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
            pc_load = branch_taken(op, flag_Z_in, flag_N_in);
            pc_inc  = !pc_load;
          end
          default: pc_inc = 1'b1;
        endcase
      end
      MEM: begin
        acc_wr_out = 1'b1;
        pc_inc     = 1'b1;
        state_nxt  = FETCH;
        if (op != OP_LD) begin
          sel_A_out     = SEL_A_ALU;
          alu_op_out    = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
          status_wr_out = 1'b1;
        end
      end
      HALT:    halted_out = 1'b1;
      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed scenarios plus a random program checked against an instruction-level model.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_data;
  logic        flag_z;
  logic        flag_n;
  logic [10:0] instr_addr;
  logic [10:0] operand;
  logic        alu_op;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        acc_wr;
  logic        status_wr;
  logic        acc_reset;
  logic        status_reset;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;

  logic [15:0] imem [0:2047];
  int          checks = 0;
  int          passed = 0;

  control_unit dut (
    .clock_in         (clk),
    .reset_n_in       (rst_n),
    .instr_data_in    (instr_data),
    .flag_Z_in        (flag_z),
    .flag_N_in        (flag_n),
    .instr_addr_out   (instr_addr),
    .operand_out      (operand),
    .alu_op_out       (alu_op),
    .sel_A_out        (sel_a),
    .sel_B_out        (sel_b),
    .acc_wr_out       (acc_wr),
    .status_wr_out    (status_wr),
    .acc_reset_out    (acc_reset),
    .status_reset_out (status_reset),
    .data_mem_rd_out  (mem_rd),
    .data_mem_wr_out  (mem_wr),
    .halted_out       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address appears one cycle later.
  always @(posedge clk) instr_data <= imem[instr_addr];

  // {acc_wr, status_wr, rd, wr, acc_reset, status_reset, halted}
  function automatic logic [6:0] strobes();
    return {acc_wr, status_wr, mem_rd, mem_wr, acc_reset, status_reset, halted};
  endfunction

  function automatic logic model_taken(input logic [4:0] op, input logic z, input logic n);
    case (op)
      5'd8:    return z;
      5'd9:    return !z;
      5'd10:   return !z && !n;
      5'd11:   return !n;
      5'd12:   return n;
      5'd13:   return n || z;
      5'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 2048; a++) imem[a] = 16'hF800;
  endtask

  // Returns during the INIT cycle right after reset release.
  task automatic reset_dut();
    @(negedge clk);
    rst_n  = 1'b0;
    flag_z = 1'b0;
    flag_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (strobes() !== 7'b0000110) $display("FAIL reset_strobes: got %b want %b", strobes(), 7'b0000110);
    else passed++;
    checks++;
    if (instr_addr !== 11'd0 || operand !== 11'd0)
      $display("FAIL reset_pc_ir: got addr %h operand %h want 0 0", instr_addr, operand);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({acc_reset, status_reset} !== 2'b11) $display("FAIL init_cycle_resets: got %b want 11", {acc_reset, status_reset});
    else passed++;
    tick();
    checks++;
    if (instr_addr !== 11'd0 || strobes() !== 7'b0)
      $display("FAIL first_fetch: got addr %h strobes %b want 0 0", instr_addr, strobes());
    else passed++;
    tick();
    checks++;
    if (strobes() !== 7'b0) $display("FAIL decode_quiet: got %b want 0", strobes());
    else passed++;
  endtask

  task automatic test_imm_branch();
    clear_mem();
    imem[0] = 16'h1805;  // LDI 5
    imem[1] = 16'h2FFB;  // ADDI -5
    imem[2] = 16'h4010;  // BEQ 0x010
    reset_dut();
    repeat (3) tick();
    checks++;
    if ({acc_wr, status_wr, sel_a} !== 4'b1001)
      $display("FAIL ldi_exec: got acc/st/selA %b want 1001", {acc_wr, status_wr, sel_a});
    else passed++;
    repeat (3) tick();
    checks++;
    if ({acc_wr, status_wr, alu_op, sel_a, sel_b} !== 6'b110101)
      $display("FAIL addi_exec: got %b want 110101", {acc_wr, status_wr, alu_op, sel_a, sel_b});
    else passed++;
    flag_z = 1'b1;
    repeat (3) tick();
    checks++;
    if (strobes() !== 7'b0) $display("FAIL beq_exec_quiet: got %b want 0", strobes());
    else passed++;
    tick();
    checks++;
    if (instr_addr !== 11'h010) $display("FAIL beq_taken: got %h want 010", instr_addr);
    else passed++;
  endtask

  task automatic test_branch_not_taken();
    clear_mem();
    imem[0] = 16'h1805;
    imem[1] = 16'h2FFB;
    imem[2] = 16'h4010;
    imem[3] = 16'h6123;  // BLT 0x123
    reset_dut();
    flag_z = 1'b0;
    flag_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (instr_addr !== 11'd3) $display("FAIL beq_not_taken: got %h want 003", instr_addr);
    else passed++;
    repeat (3) tick();
    checks++;
    if (instr_addr !== 11'h123) $display("FAIL blt_taken: got %h want 123", instr_addr);
    else passed++;
  endtask

  task automatic test_ld();
    clear_mem();
    imem[0] = 16'h17FF;  // LD 0x7FF
    reset_dut();
    repeat (3) tick();
    checks++;
    if ({mem_rd, mem_wr, acc_wr} !== 3'b100 || operand !== 11'h7FF)
      $display("FAIL ld_exec: got rd/wr/acc %b operand %h want 100 7ff", {mem_rd, mem_wr, acc_wr}, operand);
    else passed++;
    tick();
    checks++;
    if ({acc_wr, status_wr, mem_rd, sel_a} !== 5'b10000)
      $display("FAIL ld_mem: got %b want 10000", {acc_wr, status_wr, mem_rd, sel_a});
    else passed++;
    tick();
    checks++;
    if (instr_addr !== 11'd1 || strobes() !== 7'b0)
      $display("FAIL ld_latency: got addr %h strobes %b want 001 0", instr_addr, strobes());
    else passed++;
  endtask

  task automatic test_sto_wrap();
    clear_mem();
    imem[0]     = 16'h77FF;  // JMP 0x7FF
    imem[11'h7FF] = 16'h0820;  // STO 0x020
    reset_dut();
    repeat (4) tick();
    checks++;
    if (instr_addr !== 11'h7FF) $display("FAIL jmp_top: got %h want 7ff", instr_addr);
    else passed++;
    repeat (2) tick();
    checks++;
    if ({mem_wr, mem_rd, acc_wr} !== 3'b100 || operand !== 11'h020)
      $display("FAIL sto_exec: got wr/rd/acc %b operand %h want 100 020", {mem_wr, mem_rd, acc_wr}, operand);
    else passed++;
    tick();
    checks++;
    if (mem_wr !== 1'b0 || instr_addr !== 11'd0)
      $display("FAIL sto_wrap: got wr %b addr %h want 0 000", mem_wr, instr_addr);
    else passed++;
  endtask

  task automatic test_halt();
    clear_mem();
    imem[0] = 16'h1801;  // LDI 1
    imem[1] = 16'h0000;  // HLT
    reset_dut();
    repeat (7) tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (strobes() !== 7'b0000001 || instr_addr !== 11'd1)
        $display("FAIL halt_hold_%0d: got strobes %b addr %h want 0000001 001", c, strobes(), instr_addr);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_mem();
    imem[0] = 16'h2005;  // ADD 5
    reset_dut();
    repeat (4) tick();
    checks++;
    if ({acc_wr, status_wr} !== 2'b11) $display("FAIL add_mem: got %b want 11", {acc_wr, status_wr});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_wr, status_wr, acc_reset} !== 3'b001)
      $display("FAIL async_abort: got %b want 001", {acc_wr, status_wr, acc_reset});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (instr_addr !== 11'd0 || strobes() !== 7'b0)
      $display("FAIL restart_pc: got addr %h strobes %b want 000 0", instr_addr, strobes());
    else passed++;
  endtask

  // Random program, checked cycle by cycle against an instruction-level model.
  task automatic test_random();
    logic [10:0] pc;
    logic [15:0] w;
    logic [4:0]  op;
    logic [10:0] opd;
    logic        z;
    logic        n;
    logic        is_mem;
    logic [6:0]  exp_s;
    logic [1:0]  exp_sela;
    logic        exp_selb;
    logic        exp_alu;
    int          phases;
    for (int a = 0; a < 2048; a++) begin
      w        = 16'($urandom);
      w[15:11] = 5'($urandom_range(1, 31));
      imem[a]  = w;
    end
    reset_dut();
    pc = 11'd0;
    z  = 1'b0;
    n  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      w      = imem[pc];
      op     = w[15:11];
      opd    = w[10:0];
      is_mem = (op == 5'd2 || op == 5'd4 || op == 5'd6);
      phases = is_mem ? 4 : 3;
      for (int ph = 0; ph < phases; ph++) begin
        tick();
        exp_s    = 7'b0;
        exp_sela = 2'b00;
        exp_selb = 1'b0;
        exp_alu  = 1'b0;
        if (ph == 2) begin
          z      = 1'($urandom);
          n      = 1'($urandom);
          flag_z = z;
          flag_n = n;
          exp_s[4] = is_mem;
          exp_s[3] = (op == 5'd1);
          exp_s[6] = (op == 5'd3 || op == 5'd5 || op == 5'd7);
          exp_s[5] = (op == 5'd5 || op == 5'd7);
          exp_sela = (op == 5'd3) ? 2'b01 : 2'b10;
          exp_selb = 1'b1;
          exp_alu  = (op == 5'd7);
        end else if (ph == 3) begin
          exp_s[6] = 1'b1;
          exp_s[5] = (op != 5'd2);
          exp_sela = (op == 5'd2) ? 2'b00 : 2'b10;
          exp_alu  = (op == 5'd6);
        end
        checks++;
        if (strobes() !== exp_s)
          $display("FAIL rnd_strobes k%0d ph%0d op%0d: got %b want %b", k, ph, op, strobes(), exp_s);
        else passed++;
        if (exp_s[6]) begin
          checks++;
          if (sel_a !== exp_sela || (exp_sela == 2'b10 && {sel_b, alu_op} !== {exp_selb, exp_alu}))
            $display("FAIL rnd_datapath k%0d ph%0d op%0d: got selA %b selB %b alu %b want %b %b %b",
                     k, ph, op, sel_a, sel_b, alu_op, exp_sela, exp_selb, exp_alu);
          else passed++;
        end
        if (ph == 0) begin
          checks++;
          if (instr_addr !== pc) $display("FAIL rnd_fetch_addr k%0d: got %h want %h", k, instr_addr, pc);
          else passed++;
        end else if (ph >= 2) begin
          checks++;
          if (operand !== opd) $display("FAIL rnd_operand k%0d: got %h want %h", k, operand, opd);
          else passed++;
        end
      end
      if (op >= 5'd8 && op <= 5'd14 && model_taken(op, z, n)) pc = opd;
      else pc = pc + 11'd1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    flag_z = 1'b0;
    flag_n = 1'b0;
    test_reset();
    test_imm_branch();
    test_branch_not_taken();
    test_ld();
    test_sto_wrap();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the 16-bit accumulator datapath (accumulator register, ALU, sign-extender, status flags, A/B muxes).
- Holds the program counter and instruction register, and fetches from a synchronous instruction memory.
- Decodes a 5-bit opcode / 11-bit operand word and drives every datapath and data-memory control line, one instruction at a time.

Parameters:
- DATA_WIDTH, 16, instruction and data word width.
- OPERAND_WIDTH, 11, operand/address width; PC width.
- OPCODE_WIDTH, 5, opcode field width; must equal DATA_WIDTH - OPERAND_WIDTH.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- instr_data_in  input  DATA_WIDTH  instruction memory read data; valid the cycle after instr_addr_out is driven.
- flag_Z_in  input  1  datapath Z flag.
- flag_N_in  input  1  datapath N flag.
- instr_addr_out  output  OPERAND_WIDTH  PC value to instruction memory.
- operand_out  output  OPERAND_WIDTH  IR[OPERAND_WIDTH-1:0], to datapath operand_in and data-memory address.
- alu_op_out  output  1  0 = add, 1 = subtract.
- sel_A_out  output  2  accumulator source: 2'b10 ALU, 2'b01 ext, 2'b00 data memory.
- sel_B_out  output  1  ALU B source: 1 ext, 0 data memory.
- acc_wr_out  output  1  accumulator write enable.
- status_wr_out  output  1  status flag write enable.
- acc_reset_out  output  1  datapath accumulator clear (active-high).
- status_reset_out  output  1  datapath status clear (active-high).
- data_mem_rd_out  output  1  data memory read strobe.
- data_mem_wr_out  output  1  data memory write strobe (write data = datapath data_out).
- halted_out  output  1  core stopped on HLT.

Behaviour:
- Reset (reset_n_in = 0, asynchronous):
  - state = INIT, PC = 0, IR = 0.
  - All outputs 0 except acc_reset_out = status_reset_out = 1.
- All control outputs are decoded from state and IR only (Moore). PC and IR are registered.
- INIT: asserts both datapath resets for exactly one clock after reset release, then -> FETCH.
- FETCH: instr_addr_out = PC; no datapath writes; -> DECODE.
- DECODE: IR <= instr_data_in; -> EXEC.
- EXEC, by opcode (IR[15:11]):
  - HLT 00000: -> HALT; PC unchanged.
  - STO 00001: data_mem_wr_out = 1 for one cycle; PC+1; -> FETCH.
  - LD 00010, ADD 00100, SUB 00110: data_mem_rd_out = 1; -> MEM; PC unchanged.
  - LDI 00011: sel_A = 01, acc_wr = 1.
  - ADDI 00101 / SUBI 00111: sel_A = 10, sel_B = 1, alu_op = 0 / 1, acc_wr = 1, status_wr = 1.
  - LDI, ADDI, SUBI: PC+1; -> FETCH.
  - Branches, each taken when its condition holds:
    - BEQ 01000: Z.
    - BNE 01001: !Z.
    - BGT 01010: !Z & !N.
    - BGE 01011: !N.
    - BLT 01100: N.
    - BLE 01101: N | Z.
    - JMP 01110: always.
  - Branch result: taken -> PC = operand; not taken -> PC+1; -> FETCH.
  - Flags are sampled in EXEC.
  - Opcodes 01111–11111: NOP, PC+1, -> FETCH.
- MEM: memory data valid this cycle. acc_wr = 1.
  - LD: sel_A = 00.
  - ADD / SUB: sel_A = 10, sel_B = 0, alu_op = 0 / 1, status_wr = 1.
  - PC+1; -> FETCH.
- HALT: halted_out = 1; all strobes 0; remains until reset.
- Latency: 3 cycles for STO, immediates, branches and NOPs; 4 cycles for LD/ADD/SUB; first FETCH is the 2nd cycle after reset release.
- Flag/update rules:
  - status_wr only on ADD/SUB/ADDI/SUBI, so branches see flags from the last arithmetic op.
  - LD/LDI leave flags unchanged.
- PC arithmetic: modulo 2^OPERAND_WIDTH; PC = 2047 increments to 0.
- operand_out is stable from the cycle after DECODE until the next DECODE.
- Strobe exclusivity: data_mem_rd_out and data_mem_wr_out are never both 1; acc_wr_out is never 1 in FETCH/DECODE.
- Reset mid-instruction: immediate abort, no further strobes; a write strobe already active is dropped asynchronously.

Decomposition:
- control_pkg holds:
  - opcode_t enum with the encodings above;
  - state_t enum {INIT, FETCH, DECODE, EXEC, MEM, HALT};
  - SEL_A_ALU/SEL_A_EXT/SEL_A_MEM and ALU_ADD/ALU_SUB constants;
  - a branch_taken function (opcode, Z, N).
- One sub-module: program_counter, with async active-low reset, load, increment and hold.

Test Plan:
- Reset release:
  - cycle 1: acc_reset_out = status_reset_out = 1;
  - cycle 2: instr_addr_out = 0;
  - no strobes before first EXEC.
- Program LDI 5; ADDI -5; BEQ 0x010:
  - after ADDI MEM-less EXEC, status_wr = 1 with alu_op = 0, sel_A = 10, sel_B = 1;
  - BEQ with Z = 1 -> next instr_addr_out = 0x010.
- Same program with flag_Z_in = 0, flag_N_in = 1 at BEQ: PC -> 3. BLT at PC 3 with N = 1 -> PC = operand.
- LD 0x7FF: EXEC data_mem_rd_out = 1, operand_out = 0x7FF; MEM acc_wr = 1, sel_A = 00, status_wr = 0; instruction takes 4 cycles.
- STO 0x020 at PC 0x7FF: one-cycle data_mem_wr_out with operand_out = 0x020; next instr_addr_out = 0x000 (wrap).
- HLT: halted_out = 1 and PC frozen for 20 cycles; reset_n_in pulsed low mid-MEM of an ADD -> acc_wr_out drops immediately, restart at PC 0.
